// File: rtl/sa_pkg.sv
// Shared constants and state type for the systolic-array input framer.
package sa_pkg;
  localparam int DATA_WIDTH     = 1024;
  localparam int ARITH_IN_WIDTH = 16;
  localparam int N              = 32;
  localparam int M              = 31;
  localparam int PAYLOAD_W      = (M + N) * ARITH_IN_WIDTH;
  localparam int EOB_BIT        = DATA_WIDTH - 1;
  localparam int SOB_BIT        = DATA_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, RUN, PAD} framer_state_t;
endpackage

// File: rtl/skid_buffer.sv
// Two-entry registered buffer; the write-side ready is a registered
// function of occupancy, so it never depends combinationally on out_ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  logic [WIDTH-1:0] head_q, tail_q;
  logic [1:0]       cnt_q, cnt_nxt;
  logic             ready_q;
  logic             push, pop;

  assign push    = in_valid & ready_q;
  assign pop     = (cnt_q != 2'd0) & out_ready;
  assign cnt_nxt = cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      cnt_q   <= cnt_nxt;
      ready_q <= (cnt_nxt != 2'd2);
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_data;
          else               tail_q <= in_data;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          // with two entries the new beat queues behind the promoted tail
          if (cnt_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = cnt_q;
endmodule

// File: rtl/sa_block_framer.sv
// Cuts the DMA beat stream into blocks of cfg_k_len_i beats, tags SOB/EOB,
// zero-pads truncated blocks and registers the result through a skid buffer.
module sa_block_framer #(
  parameter int DATA_WIDTH     = sa_pkg::DATA_WIDTH,
  parameter int ARITH_IN_WIDTH = sa_pkg::ARITH_IN_WIDTH,
  parameter int N              = sa_pkg::N,
  parameter int M              = sa_pkg::M,
  parameter int KW             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rts_i,
  output logic                  rtr_o,
  input  logic                  sow_i,
  input  logic                  eow_dma_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rtr_i,
  output logic                  rts_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [KW-1:0]         cfg_k_len_i,
  input  logic                  cfg_clr_i,
  output logic [31:0]           blk_cnt_o,
  output logic                  busy_o,
  output logic                  err_trunc_o
);
  import sa_pkg::*;

  localparam int PLD_W = (M + N) * ARITH_IN_WIDTH;
  localparam int SOB_B = DATA_WIDTH - 2;
  localparam int EOB_B = DATA_WIDTH - 1;

  if (PLD_W > DATA_WIDTH - 2) begin : g_payload_too_wide
    $error("sa_block_framer: payload does not leave room for SOB/EOB flags");
  end
  if (DATA_WIDTH == sa_pkg::DATA_WIDTH &&
      (PLD_W != sa_pkg::PAYLOAD_W || SOB_B != sa_pkg::SOB_BIT || EOB_B != sa_pkg::EOB_BIT))
  begin : g_pkg_mismatch
    $error("sa_block_framer: parameters disagree with sa_pkg layout");
  end

  framer_state_t         state_q;
  logic [KW-1:0]         k_q, cnt_q, k_eff;
  logic [31:0]           blk_q;
  logic                  err_q;
  logic                  accept, last, beat_eob, push, push_eob, buf_ready;
  logic [DATA_WIDTH-1:0] push_word;
  logic [1:0]            occ;
  logic                  unused_hi;

  assign unused_hi = ^data_i[DATA_WIDTH-1:PLD_W];
  assign k_eff     = (cfg_k_len_i == '0) ? KW'(1) : cfg_k_len_i;
  assign rtr_o     = buf_ready & (state_q != PAD);
  assign accept    = rts_i & rtr_o;

  always_comb begin
    last      = (cnt_q == k_q - KW'(1));
    beat_eob  = (state_q == IDLE) ? (k_eff == KW'(1)) : last;
    push      = (state_q == PAD) ? buf_ready : accept;
    push_eob  = beat_eob;
    push_word = '0;
    if (state_q != PAD) push_word[PLD_W-1:0] = data_i[PLD_W-1:0];
    push_word[SOB_B] = (state_q == IDLE);
    push_word[EOB_B] = push_eob;
  end

  // Block sequencing, sticky truncation flag and completed-block counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          k_q   <= k_eff;
          cnt_q <= KW'(1);
          if (!beat_eob) state_q <= eow_dma_i ? PAD : RUN;
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + KW'(1);
          if (beat_eob)       state_q <= IDLE;
          else if (eow_dma_i) state_q <= PAD;
        end
        PAD: if (push) begin
          cnt_q <= cnt_q + KW'(1);
          if (push_eob) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (cfg_clr_i)                             err_q <= 1'b0;
      else if (accept && eow_dma_i && !beat_eob) err_q <= 1'b1;

      if (cfg_clr_i)              blk_q <= '0;
      else if (accept && sow_i)   blk_q <= (push && push_eob) ? 32'd1 : 32'd0;
      else if (push && push_eob)  blk_q <= blk_q + 32'd1;
    end
  end

  skid_buffer #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (buf_ready),
    .in_data   (push_word),
    .out_valid (rts_o),
    .out_ready (rtr_i),
    .out_data  (data_o),
    .occupancy (occ)
  );

  assign blk_cnt_o   = blk_q;
  assign err_trunc_o = err_q;
  assign busy_o      = (state_q != IDLE) | (occ != 2'd0);
endmodule

// File: tb/tb_sa_block_framer.sv
// Scoreboard bench for sa_block_framer: a behavioural block model queues
// expected output beats as input beats are accepted; a monitor pops and compares.
module tb_sa_block_framer;
  import sa_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int PW = PAYLOAD_W;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rts_i = 1'b0, sow_i = 1'b0, eow_dma_i = 1'b0;
  logic          rtr_i = 1'b1, cfg_clr_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [KW-1:0] cfg_k_len_i = '0;
  logic          rtr_o, rts_o, busy_o, err_trunc_o;
  logic [DW-1:0] data_o;
  logic [31:0]   blk_cnt_o;

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp, prev_data;
  logic          prev_stall = 1'b0;
  int  m_k = 1, m_cnt = 0, m_blk = 0;
  bit  m_inblk = 0;
  int  n_out = 0, wait_cycles = 0, stall_acc = 0, max_stall_acc = 0;
  bit  bp_en = 0;

  sa_block_framer dut (
    .clk(clk), .rst(rst), .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i),
    .eow_dma_i(eow_dma_i), .data_i(data_i), .rtr_i(rtr_i), .rts_o(rts_o),
    .data_o(data_o), .cfg_k_len_i(cfg_k_len_i), .cfg_clr_i(cfg_clr_i),
    .blk_cnt_o(blk_cnt_o), .busy_o(busy_o), .err_trunc_o(err_trunc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  always @(posedge clk) begin
    #2;
    if (bp_en) rtr_i = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      stall_acc  = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (rts_o !== 1'b1 || data_o !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: rts_o=%b data_lo=%h, required rts_o=1 data_lo=%h",
                   rts_o, data_o[31:0], prev_data[31:0]);
        end
      end
      if (rts_o && rtr_i) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got hi=%h lo=%h, required no beat",
                   data_o[DW-1:DW-32], data_o[31:0]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_o !== mon_exp) begin
            errors++;
            $display("FAIL data_o beat %0d: got hi=%h lo=%h, required hi=%h lo=%h",
                     n_out, data_o[DW-1:DW-32], data_o[31:0],
                     mon_exp[DW-1:DW-32], mon_exp[31:0]);
          end
        end
      end
      prev_stall = rts_o & ~rtr_i;
      prev_data  = data_o;
      if (rtr_i) stall_acc = 0;
      else if (rts_i && rtr_o) begin
        stall_acc++;
        if (stall_acc > max_stall_acc) max_stall_acc = stall_acc;
      end
    end
  end

  task automatic model_beat(input logic [PW-1:0] pl, input bit sow, input bit eow, input int kcfg);
    bit sob, eob;
    logic [DW-1:0] w;
    if (!m_inblk) begin
      m_k   = (kcfg == 0) ? 1 : kcfg;
      m_cnt = 0;
      sob   = 1;
    end else sob = 0;
    eob = (m_cnt == m_k - 1);
    m_cnt++;
    if (sow) m_blk = 0;
    w = '0;
    w[PW-1:0] = pl;
    w[SOB_BIT] = sob;
    w[EOB_BIT] = eob;
    exp_q.push_back(w);
    if (eob) begin
      m_blk++;
      m_inblk = 0;
    end else if (eow) begin
      while (m_cnt < m_k) begin
        m_cnt++;
        w = '0;
        w[EOB_BIT] = (m_cnt == m_k);
        exp_q.push_back(w);
      end
      m_blk++;
      m_inblk = 0;
    end else m_inblk = 1;
  endtask

  task automatic send_beat(input bit sow, input bit eow, input int kcfg);
    logic [PW-1:0] pl;
    bit acc, ok;
    int n;
    pl = '0;
    pl[31:0] = $urandom;
    pl[PW-1:PW-32] = $urandom;
    rts_i = 1'b1; sow_i = sow; eow_dma_i = eow;
    cfg_k_len_i = kcfg[KW-1:0];
    data_i = '1;
    data_i[PW-1:0] = pl;
    ok = 0; n = 0;
    while (n < 200) begin
      acc = rtr_o;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
      wait_cycles++;
      n++;
    end
    rts_i = 1'b0; sow_i = 1'b0; eow_dma_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: beat not accepted in %0d cycles, required acceptance", n);
    end else model_beat(pl, sow, eow, kcfg);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d busy_o=%b, required pending=0 busy_o=0", exp_q.size(), busy_o);
    end
  endtask

  task automatic pulse_clear();
    cfg_clr_i = 1'b1;
    @(posedge clk); #1;
    cfg_clr_i = 1'b0;
    m_blk = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({rtr_o, rts_o, busy_o, err_trunc_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rtr/rts/busy/err=%b, required 0000", {rtr_o, rts_o, busy_o, err_trunc_o});
    end
    checks++;
    if (data_o !== '0 || blk_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: data_lo=%h blk=%0d, required 0 and 0", data_o[31:0], blk_cnt_o);
    end
    rst = 1'b0;
    checks++;
    if (rtr_o !== 1'b0) begin
      errors++;
      $display("FAIL rtr_after_release: rtr_o=%b, required 0", rtr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (rtr_o !== 1'b1) begin
      errors++;
      $display("FAIL rtr_rise: rtr_o=%b, required 1", rtr_o);
    end
  endtask

  task automatic test_normal();
    int n0 = n_out;
    wait_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(1'b0, 1'b0, 4);
      if (i == 0) begin
        checks++;
        if (rts_o !== 1'b1 || data_o[SOB_BIT] !== 1'b1) begin
          errors++;
          $display("FAIL latency: rts_o=%b sob=%b one cycle after accept, required 1 1", rts_o, data_o[SOB_BIT]);
        end
      end
    end
    checks++;
    if (wait_cycles != 0) begin
      errors++;
      $display("FAIL input_bubbles: %0d stall cycles, required 0", wait_cycles);
    end
    drain();
    checks++;
    if (blk_cnt_o !== 32'd2 || n_out - n0 != 8) begin
      errors++;
      $display("FAIL normal_count: blk=%0d beats=%0d, required 2 and 8", blk_cnt_o, n_out - n0);
    end
  endtask

  task automatic test_single();
    pulse_clear();
    for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 0);
    drain();
    checks++;
    if (blk_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL single_count: blk=%0d, required 3", blk_cnt_o);
    end
  endtask

  task automatic test_truncation();
    int lowc = 0, n = 0;
    pulse_clear();
    send_beat(1'b0, 1'b0, 5);
    send_beat(1'b0, 1'b0, 5);
    send_beat(1'b0, 1'b1, 5);
    while (rtr_o === 1'b0 && n < 10) begin
      lowc++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (lowc != 2) begin
      errors++;
      $display("FAIL pad_rtr_low: %0d cycles, required 2", lowc);
    end
    drain();
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (err_trunc_o !== 1'b1 || blk_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL trunc_flags: err=%b blk=%0d, required 1 and 1", err_trunc_o, blk_cnt_o);
    end
    pulse_clear();
    checks++;
    if (err_trunc_o !== 1'b0 || blk_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL trunc_clear: err=%b blk=%0d, required 0 and 0", err_trunc_o, blk_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    pulse_clear();
    max_stall_acc = 0;
    bp_en = 1;
    for (int i = 0; i < 100; i++) send_beat(1'b0, (i == 99), 7);
    bp_en = 0;
    rtr_i = 1'b1;
    drain();
    checks++;
    if (max_stall_acc > 2) begin
      errors++;
      $display("FAIL stall_accepts: %0d beats accepted while stalled, required at most 2", max_stall_acc);
    end
    checks++;
    if (blk_cnt_o !== 32'd15 || err_trunc_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_count: blk=%0d err=%b, required 15 and 1", blk_cnt_o, err_trunc_o);
    end
  endtask

  task automatic test_sow_clear();
    pulse_clear();
    for (int i = 0; i < 6; i++) send_beat(1'b0, 1'b0, 2);
    checks++;
    if (blk_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL pre_sow_count: blk=%0d, required 3", blk_cnt_o);
    end
    send_beat(1'b1, 1'b0, 2);
    checks++;
    if (blk_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL sow_restart: blk=%0d, required 0", blk_cnt_o);
    end
    send_beat(1'b0, 1'b0, 2);
    checks++;
    if (blk_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL sow_eob: blk=%0d, required 1", blk_cnt_o);
    end
    send_beat(1'b0, 1'b0, 2);
    cfg_clr_i = 1'b1;
    send_beat(1'b0, 1'b0, 2);
    cfg_clr_i = 1'b0;
    m_blk = 0;
    checks++;
    if (blk_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL clear_wins: blk=%0d, required 0", blk_cnt_o);
    end
    drain();
  endtask

  task automatic test_reset_midblock();
    int n0;
    send_beat(1'b0, 1'b0, 6);
    send_beat(1'b0, 1'b0, 6);
    rst = 1'b1;
    exp_q.delete();
    m_inblk = 0;
    m_blk = 0;
    #1;
    checks++;
    if ({rts_o, rtr_o, busy_o, err_trunc_o} !== 4'b0 || data_o !== '0 || blk_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL midblock_reset: rts/rtr/busy/err=%b blk=%0d data_lo=%h, required all 0",
               {rts_o, rtr_o, busy_o, err_trunc_o}, blk_cnt_o, data_o[31:0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = n_out;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (n_out != n0 || rts_o !== 1'b0) begin
      errors++;
      $display("FAIL no_pad_after_reset: %0d beats rts_o=%b, required 0 beats rts_o=0", n_out - n0, rts_o);
    end
    send_beat(1'b0, 1'b0, 6);
    checks++;
    if (rts_o !== 1'b1 || data_o[SOB_BIT] !== 1'b1) begin
      errors++;
      $display("FAIL sob_after_reset: rts_o=%b sob=%b, required 1 1", rts_o, data_o[SOB_BIT]);
    end
    for (int i = 0; i < 5; i++) send_beat(1'b0, 1'b0, 6);
    drain();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_single();
    test_truncation();
    test_backpressure();
    test_sow_clear();
    test_reset_midblock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
